// File: rtl/strength_resolve_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : strength_pkg
//  Description : Shared types and helpers for the sequential strength
//                resolver: 4-state value and drive-strength encodings, the
//                resolved-result record and the accumulator resolve function.
//  Contents    : STR_W, VAL_W       - field widths
//                val4_e             - 4-state value encoding
//                strength_e         - IEEE 1800 drive strength ladder
//                res_t              - {val, str, conflict} result record
//                str_max()          - larger of two strengths
//                resolve_acc()      - final value/strength from acc0/acc1
//  Revision    : 1.0 - initial release
// ============================================================================
package strength_pkg;

    localparam int STR_W = 3;
    localparam int VAL_W = 2;

    typedef enum logic [VAL_W-1:0] {
        V0 = 2'b00,
        V1 = 2'b01,
        VZ = 2'b10,
        VX = 2'b11
    } val4_e;

    typedef enum logic [STR_W-1:0] {
        HIGHZ  = 3'd0,
        SMALL  = 3'd1,
        MEDIUM = 3'd2,
        WEAK   = 3'd3,
        LARGE  = 3'd4,
        PULL   = 3'd5,
        STRONG = 3'd6,
        SUPPLY = 3'd7
    } strength_e;

    typedef struct packed {
        val4_e              val;
        logic [STR_W-1:0]   str;
        logic               conflict;
    } res_t;

    function automatic logic [STR_W-1:0] str_max(
        input logic [STR_W-1:0] a,
        input logic [STR_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // acc0 is the strongest pull toward 0, acc1 the strongest toward 1.
    // A tie between non-highz sides is an x at that strength.
    function automatic res_t resolve_acc(
        input logic [STR_W-1:0] acc0,
        input logic [STR_W-1:0] acc1
    );
        res_t r;
        r.val      = VZ;
        r.str      = '0;
        r.conflict = 1'b0;
        if (acc0 > acc1) begin
            r.val = V0;
            r.str = acc0;
        end else if (acc1 > acc0) begin
            r.val = V1;
            r.str = acc1;
        end else if (acc0 != '0) begin
            r.val      = VX;
            r.str      = acc0;
            r.conflict = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/strength_fold.sv
`default_nettype none
// ============================================================================
//  Module      : strength_fold
//  Description : Combinational fold of one driver into the 0-side and 1-side
//                strength accumulators.
//  Ports       : acc0_i/acc1_i     - current accumulators
//                en_i              - driver enable (0 = no contribution)
//                val_i             - driver 4-state value
//                s0_i/s1_i         - driver strength0 / strength1
//                acc0_n_o/acc1_n_o - updated accumulators
//  Revision    : 1.0 - initial release
// ============================================================================
module strength_fold
    import strength_pkg::*;
(
    input  logic [STR_W-1:0] acc0_i,
    input  logic [STR_W-1:0] acc1_i,
    input  logic             en_i,
    input  logic [VAL_W-1:0] val_i,
    input  logic [STR_W-1:0] s0_i,
    input  logic [STR_W-1:0] s1_i,
    output logic [STR_W-1:0] acc0_n_o,
    output logic [STR_W-1:0] acc1_n_o
);

    always_comb begin
        acc0_n_o = acc0_i;
        acc1_n_o = acc1_i;
        if (en_i) begin
            unique case (val_i)
                V0: acc0_n_o = str_max(acc0_i, s0_i);
                V1: acc1_n_o = str_max(acc1_i, s1_i);
                // An x driver pulls both ways at its respective strengths.
                VX: begin
                    acc0_n_o = str_max(acc0_i, s0_i);
                    acc1_n_o = str_max(acc1_i, s1_i);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/strength_resolve_seq.sv
`default_nettype none
// ============================================================================
//  Module      : strength_resolve_seq
//  Description : Sequential resolver for one multi-driver net. Snapshots
//                N_DRV (value, strength0, strength1) tuples on start, folds
//                one driver per cycle and publishes the resolved value and
//                strength with a one-cycle valid pulse.
//  Ports       : clk          - clock, rising edge
//                rst_n        - asynchronous active-low reset
//                start_i      - resolution request, taken only when idle
//                drv_en_i     - per-driver enable
//                drv_val_i    - per-driver value, driver i at [2i+1:2i]
//                drv_s0_i     - per-driver strength0, driver i at [3i+2:3i]
//                drv_s1_i     - per-driver strength1, same packing
//                busy_o       - scan or result cycle in progress
//                res_valid_o  - one-cycle pulse when res_* updates
//                res_val_o    - resolved value
//                res_str_o    - resolved strength
//                conflict_o   - last result was an equal-strength tie
//  Revision    : 1.0 - initial release
// ============================================================================
module strength_resolve_seq
    import strength_pkg::*;
#(
    parameter int N_DRV = 3,
    parameter int CNT_W = $clog2(N_DRV + 1)
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [N_DRV-1:0]       drv_en_i,
    input  logic [2*N_DRV-1:0]     drv_val_i,
    input  logic [3*N_DRV-1:0]     drv_s0_i,
    input  logic [3*N_DRV-1:0]     drv_s1_i,
    output logic                   busy_o,
    output logic                   res_valid_o,
    output logic [VAL_W-1:0]       res_val_o,
    output logic [STR_W-1:0]       res_str_o,
    output logic                   conflict_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_DRV - 1);

    state_e                 state_q, state_d;

    logic [N_DRV-1:0]       sh_en_q;
    logic [2*N_DRV-1:0]     sh_val_q;
    logic [3*N_DRV-1:0]     sh_s0_q;
    logic [3*N_DRV-1:0]     sh_s1_q;

    logic [STR_W-1:0]       acc0_q, acc1_q;
    logic [CNT_W-1:0]       idx_q;

    logic                   res_valid_q;
    logic [VAL_W-1:0]       res_val_q;
    logic [STR_W-1:0]       res_str_q;
    logic                   conflict_q;

    logic                   load;
    logic                   fold;
    logic                   publish;

    logic                   cur_en;
    logic [VAL_W-1:0]       cur_val;
    logic [STR_W-1:0]       cur_s0;
    logic [STR_W-1:0]       cur_s1;
    logic [STR_W-1:0]       acc0_d, acc1_d;
    res_t                   res_d;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        load    = 1'b0;
        fold    = 1'b0;
        publish = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                busy_o = 1'b1;
                fold   = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_o  = 1'b1;
                publish = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Select the shadow driver addressed by idx
    // ------------------------------------------------------------------
    always_comb begin
        cur_en  = 1'b0;
        cur_val = VZ;
        cur_s0  = '0;
        cur_s1  = '0;
        for (int i = 0; i < N_DRV; i++) begin
            if (idx_q == CNT_W'(i)) begin
                cur_en  = sh_en_q[i];
                cur_val = sh_val_q[2*i +: 2];
                cur_s0  = sh_s0_q[3*i +: 3];
                cur_s1  = sh_s1_q[3*i +: 3];
            end
        end
    end

    strength_fold u_fold (
        .acc0_i   (acc0_q),
        .acc1_i   (acc1_q),
        .en_i     (cur_en),
        .val_i    (cur_val),
        .s0_i     (cur_s0),
        .s1_i     (cur_s1),
        .acc0_n_o (acc0_d),
        .acc1_n_o (acc1_d)
    );

    assign res_d = resolve_acc(acc0_q, acc1_q);

    // ------------------------------------------------------------------
    // Snapshot, accumulators and scan index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en_q  <= '0;
            sh_val_q <= '0;
            sh_s0_q  <= '0;
            sh_s1_q  <= '0;
            acc0_q   <= '0;
            acc1_q   <= '0;
            idx_q    <= '0;
        end else if (load) begin
            sh_en_q  <= drv_en_i;
            sh_val_q <= drv_val_i;
            sh_s0_q  <= drv_s0_i;
            sh_s1_q  <= drv_s1_i;
            acc0_q   <= '0;
            acc1_q   <= '0;
            idx_q    <= '0;
        end else if (fold) begin
            acc0_q   <= acc0_d;
            acc1_q   <= acc1_d;
            idx_q    <= idx_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result registers: held until the next DONE, never cleared by start
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_val_q   <= VZ;
            res_str_q   <= '0;
            conflict_q  <= 1'b0;
        end else begin
            res_valid_q <= publish;
            if (publish) begin
                res_val_q  <= res_d.val;
                res_str_q  <= res_d.str;
                conflict_q <= res_d.conflict;
            end
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_val_o   = res_val_q;
    assign res_str_o   = res_str_q;
    assign conflict_o  = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_strength_resolve_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_strength_resolve_seq
//  Description : Self-checking bench for strength_resolve_seq (N_DRV=3):
//                directed vector table, hand-written multi-cycle sequences
//                and randomized vectors against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_strength_resolve_seq;

    localparam int N   = 3;
    localparam int LAT = N + 1;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   drv_en;
    logic [2*N-1:0] drv_val;
    logic [3*N-1:0] drv_s0;
    logic [3*N-1:0] drv_s1;
    logic           busy;
    logic           res_valid;
    logic [1:0]     res_val;
    logic [2:0]     res_str;
    logic           conflict;

    int checks   = 0;
    int failures = 0;

    strength_resolve_seq #(.N_DRV(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .drv_en_i    (drv_en),
        .drv_val_i   (drv_val),
        .drv_s0_i    (drv_s0),
        .drv_s1_i    (drv_s1),
        .busy_o      (busy),
        .res_valid_o (res_valid),
        .res_val_o   (res_val),
        .res_str_o   (res_str),
        .conflict_o  (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   en;
        logic [2*N-1:0] val;
        logic [3*N-1:0] s0;
        logic [3*N-1:0] s1;
        logic [1:0]     ev;
        logic [2:0]     es;
        logic           ec;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference: strongest 0-side and 1-side contributions, then compare.
    task automatic model(input logic [N-1:0] en, input logic [2*N-1:0] val,
                         input logic [3*N-1:0] s0, input logic [3*N-1:0] s1,
                         output logic [1:0] v, output logic [2:0] s, output logic c);
        int a0 = 0;
        int a1 = 0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                logic [1:0] dv;
                dv = val[2*i +: 2];
                if (dv == 2'b00 || dv == 2'b11) a0 = (int'(s0[3*i +: 3]) > a0) ? int'(s0[3*i +: 3]) : a0;
                if (dv == 2'b01 || dv == 2'b11) a1 = (int'(s1[3*i +: 3]) > a1) ? int'(s1[3*i +: 3]) : a1;
            end
        end
        c = 1'b0;
        if (a0 > a1)      begin v = 2'b00; s = 3'(a0); end
        else if (a1 > a0) begin v = 2'b01; s = 3'(a1); end
        else if (a0 != 0) begin v = 2'b11; s = 3'(a0); c = 1'b1; end
        else              begin v = 2'b10; s = 3'd0; end
    endtask

    task automatic drive(input logic [N-1:0] en, input logic [2*N-1:0] val,
                         input logic [3*N-1:0] s0, input logic [3*N-1:0] s1);
        drv_en  = en;
        drv_val = val;
        drv_s0  = s0;
        drv_s1  = s1;
    endtask

    // Waits (bounded) for res_valid; lat counts edges since the start edge.
    task automatic wait_valid(inout int lat);
        while (res_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic resolve_and_check(input string tag, input logic [N-1:0] en,
                                     input logic [2*N-1:0] val, input logic [3*N-1:0] s0,
                                     input logic [3*N-1:0] s1, input logic [1:0] ev,
                                     input logic [2:0] es, input logic ec);
        int lat;
        @(negedge clk);
        drive(en, val, s0, s1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_busy_at_valid"}, 32'(busy), 32'd0);
        chk({tag, "_val"}, 32'(res_val), 32'(ev));
        chk({tag, "_str"}, 32'(res_str), 32'(es));
        chk({tag, "_conf"}, 32'(conflict), 32'(ec));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [1:0] mv;
        logic [2:0] ms;
        logic       mc;

        // en, val {d2,d1,d0}, s0 {d2,d1,d0}, s1 {d2,d1,d0}, expected v/s/c
        tbl[0] = '{3'b111, 6'b110100, {3'd6, 3'd5, 3'd3}, {3'd6, 3'd5, 3'd3}, 2'b11, 3'd6, 1'b1};
        tbl[1] = '{3'b011, 6'b110100, {3'd6, 3'd5, 3'd3}, {3'd6, 3'd5, 3'd3}, 2'b01, 3'd5, 1'b0};
        tbl[2] = '{3'b001, 6'b110100, {3'd6, 3'd5, 3'd3}, {3'd6, 3'd5, 3'd3}, 2'b00, 3'd3, 1'b0};
        tbl[3] = '{3'b000, 6'b110100, {3'd6, 3'd5, 3'd3}, {3'd6, 3'd5, 3'd3}, 2'b10, 3'd0, 1'b0};
        tbl[4] = '{3'b111, 6'b101010, {3'd6, 3'd5, 3'd3}, {3'd6, 3'd5, 3'd3}, 2'b10, 3'd0, 1'b0};
        tbl[5] = '{3'b111, 6'b010100, {3'd0, 3'd0, 3'd7}, {3'd3, 3'd6, 3'd0}, 2'b00, 3'd7, 1'b0};
        tbl[6] = '{3'b111, 6'b100100, {3'd0, 3'd0, 3'd3}, {3'd0, 3'd3, 3'd0}, 2'b11, 3'd3, 1'b1};
        tbl[7] = '{3'b111, 6'b101000, {3'd0, 3'd0, 3'd0}, {3'd7, 3'd7, 3'd7}, 2'b10, 3'd0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        drive('0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_val", 32'(res_val), 32'd2);
        chk("rst_str", 32'(res_str), 32'd0);
        chk("rst_conf", 32'(conflict), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- Directed table ----------------
        for (int i = 0; i < 8; i++) begin
            resolve_and_check($sformatf("tbl%0d", i), tbl[i].en, tbl[i].val, tbl[i].s0,
                              tbl[i].s1, tbl[i].ev, tbl[i].es, tbl[i].ec);
        end

        // ---------------- Start while busy ignored; start in valid cycle accepted ----
        @(negedge clk);
        drive(tbl[0].en, tbl[0].val, tbl[0].s0, tbl[0].s1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        lat++;
        @(negedge clk);
        drive(tbl[5].en, tbl[5].val, tbl[5].s0, tbl[5].s1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        wait_valid(lat);
        chk("ign_lat", 32'(lat), 32'(LAT));
        chk("ign_val", 32'(res_val), 32'd3);
        chk("ign_str", 32'(res_str), 32'd6);
        chk("ign_conf", 32'(conflict), 32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_valid_low", 32'(res_valid), 32'd0);
        chk("b2b_hold_val", 32'(res_val), 32'd3);
        wait_valid(lat);
        chk("b2b_lat", 32'(lat), 32'(LAT));
        chk("b2b_val", 32'(res_val), 32'd0);
        chk("b2b_str", 32'(res_str), 32'd7);
        chk("b2b_conf", 32'(conflict), 32'd0);

        // ---------------- Reset during SCAN ----------------
        @(negedge clk);
        drive(tbl[0].en, tbl[0].val, tbl[0].s0, tbl[0].s1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(res_valid), 32'd0);
        chk("mrst_val", 32'(res_val), 32'd2);
        chk("mrst_str", 32'(res_str), 32'd0);
        chk("mrst_conf", 32'(conflict), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (res_valid === 1'b1 || busy === 1'b1) seen++;
            end
            chk("mrst_no_pulse", 32'(seen), 32'd0);
        end
        resolve_and_check("mrst_fresh", tbl[0].en, tbl[0].val, tbl[0].s0, tbl[0].s1,
                          2'b11, 3'd6, 1'b1);

        // ---------------- Randomized against the model ----------------
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0]   en;
            logic [2*N-1:0] val;
            logic [3*N-1:0] s0;
            logic [3*N-1:0] s1;
            en  = N'($urandom);
            val = (2*N)'($urandom);
            s0  = (3*N)'($urandom);
            s1  = (3*N)'($urandom);
            model(en, val, s0, s1, mv, ms, mc);
            resolve_and_check($sformatf("rnd%0d", r), en, val, s0, s1, mv, ms, mc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
